// File: rtl/rv_iopmp_entry_scanner.sv
// IOPMP entry scanner: walks [entry_start_i, entry_end_i) one entry per cycle and
// resolves a single allow/deny verdict. Optional macro RV_IOPMP_SCAN_EARLY_EXIT_EN.
package rv_iopmp_pkg;
    typedef struct packed { logic x; logic w; logic r; } access_t;
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_TOR   = 2'd1,
        MODE_NA4   = 2'd2,
        MODE_NAPOT = 2'd3
    } mode_t;
endpackage

// Per-entry comparator: match = any byte overlaps, allow = fully inside and permitted.
module rv_iopmp_entry #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int NBW        = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [NBW-1:0]        num_bytes_i,
    input  rv_iopmp_pkg::access_t type_i,
    input  logic [2*LEN-1:0]      prev_addr_i,
    input  logic [LEN-1:0]        entry_addr_i,
    input  logic [LEN-1:0]        entry_addrh_i,
    input  rv_iopmp_pkg::mode_t   mode_i,
    input  logic [2:0]            perm_i,
    output logic                  match_o,
    output logic                  allow_o
);
    // Entry registers hold word addresses; compare in bytes with headroom for the carry.
    localparam int CW = ((ADDR_WIDTH > 2*LEN) ? ADDR_WIDTH : 2*LEN) + 3;

    logic [2*LEN-1:0] w_ent, w_mask;
    logic [CW-1:0]    w_lo, w_hi, w_beg, w_end;
    logic [2:0]       w_type;
    logic             w_overlap, w_inside;

    assign w_ent  = {entry_addrh_i, entry_addr_i};
    assign w_mask = w_ent ^ (w_ent + (2*LEN)'(1));
    assign w_beg  = CW'(addr_i);
    assign w_end  = w_beg + CW'(num_bytes_i);
    assign w_type = type_i;

    always_comb begin
        w_lo = '0;
        w_hi = '0;
        case (mode_i)
            rv_iopmp_pkg::MODE_TOR: begin
                w_lo = CW'(prev_addr_i) << 2;
                w_hi = CW'(w_ent) << 2;
            end
            rv_iopmp_pkg::MODE_NA4: begin
                w_lo = CW'(w_ent) << 2;
                w_hi = (CW'(w_ent) << 2) + CW'(4);
            end
            rv_iopmp_pkg::MODE_NAPOT: begin
                w_lo = CW'(w_ent & ~w_mask) << 2;
                w_hi = (CW'(w_ent & ~w_mask) << 2) + ((CW'(w_mask) + CW'(1)) << 2);
            end
            default: ;
        endcase
    end

    assign w_overlap = (w_lo < w_hi) && (w_beg < w_hi) && (w_end > w_lo);
    assign w_inside  = (w_beg >= w_lo) && (w_end <= w_hi);
    assign match_o   = w_overlap;
    assign allow_o   = w_overlap && w_inside && ((w_type & ~perm_i) == 3'b000);
endmodule

module rv_iopmp_entry_scanner #(
    parameter  int NUM_ENTRY  = 16,
    parameter  int LEN        = 32,
    parameter  int ADDR_WIDTH = 64,
    parameter  int DATA_WIDTH = 64,
    localparam int IW         = $clog2(NUM_ENTRY) + 1,
    localparam int NBW        = $clog2(DATA_WIDTH/8) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NBW-1:0]        req_num_bytes_i,
    input  rv_iopmp_pkg::access_t req_type_i,
    input  logic [IW-1:0]         entry_start_i,
    input  logic [IW-1:0]         entry_end_i,
    input  logic [IW-1:0]         prio_entry_i,
    output logic [IW-2:0]         entry_idx_o,
    input  logic [LEN-1:0]        entry_addr_i,
    input  logic [LEN-1:0]        entry_addrh_i,
    input  rv_iopmp_pkg::mode_t   entry_mode_i,
    input  logic [2:0]            entry_perm_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_allow_o,
    output logic                  rsp_hit_o,
    output logic [1:0]            rsp_err_o,
    output logic [IW-2:0]         rsp_entry_idx_o
);
    typedef enum logic [1:0] { S_IDLE, S_SCAN, S_RESP } state_t;

    state_t                r_state, w_state_nxt;
    logic [IW-1:0]         r_idx, r_end, r_prio;
    logic                  r_pf;
    logic [2*LEN-1:0]      r_prev;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NBW-1:0]        r_nb;
    rv_iopmp_pkg::access_t r_type;
    logic                  r_granted, r_cand;
    logic [IW-2:0]         r_gidx, r_cidx;
    logic                  r_allow, r_hit;
    logic [1:0]            r_err;
    logic [IW-2:0]         r_ridx;

    logic w_accept, w_empty, w_match, w_allow, w_eval, w_is_prio, w_last;
    logic w_prio_hit, w_np_grant, w_np_deny, w_early, w_done;
    logic [IW-2:0] w_cur;

    rv_iopmp_entry #(.LEN(LEN), .ADDR_WIDTH(ADDR_WIDTH), .NBW(NBW)) u_entry (
        .addr_i        (r_addr),
        .num_bytes_i   (r_nb),
        .type_i        (r_type),
        .prev_addr_i   (r_prev),
        .entry_addr_i  (entry_addr_i),
        .entry_addrh_i (entry_addrh_i),
        .mode_i        (entry_mode_i),
        .perm_i        (entry_perm_i),
        .match_o       (w_match),
        .allow_o       (w_allow)
    );

    assign w_accept   = req_valid_i & req_ready_o;
    assign w_empty    = entry_start_i >= entry_end_i;
    assign w_cur      = r_idx[IW-2:0];
    assign w_eval     = (r_state == S_SCAN) & ~r_pf;
    assign w_is_prio  = r_idx < r_prio;
    assign w_last     = r_idx == (r_end - IW'(1));
    assign w_prio_hit = w_eval & w_is_prio & w_match;
    assign w_np_grant = w_eval & ~w_is_prio & w_match & w_allow;
    assign w_np_deny  = w_eval & ~w_is_prio & w_match & ~w_allow;
`ifdef RV_IOPMP_SCAN_EARLY_EXIT_EN
    assign w_early    = w_np_grant;
`else
    assign w_early    = 1'b0;
`endif
    assign w_done     = w_eval & (w_prio_hit | w_early | w_last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid_i) w_state_nxt = w_empty ? S_RESP : S_SCAN;
            S_SCAN:  if (w_done)      w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o     = (r_state == S_IDLE);
        rsp_valid_o     = (r_state == S_RESP);
        entry_idx_o     = w_cur;
        rsp_allow_o     = r_allow;
        rsp_hit_o       = r_hit;
        rsp_err_o       = r_err;
        rsp_entry_idx_o = r_ridx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx <= '0; r_end <= '0; r_prio <= '0; r_pf <= 1'b0; r_prev <= '0;
            r_addr <= '0; r_nb <= '0; r_type <= '0;
            r_granted <= 1'b0; r_cand <= 1'b0; r_gidx <= '0; r_cidx <= '0;
            r_allow <= 1'b0; r_hit <= 1'b0; r_err <= 2'd0; r_ridx <= '0;
        end else if (w_accept) begin
            r_addr    <= req_addr_i;
            r_nb      <= req_num_bytes_i;
            r_type    <= req_type_i;
            r_end     <= entry_end_i;
            r_prio    <= prio_entry_i;
            r_granted <= 1'b0;
            r_cand    <= 1'b0;
            if (w_empty) begin
                r_allow <= 1'b0; r_hit <= 1'b0; r_err <= 2'd2; r_ridx <= '0;
            end else if (entry_start_i == '0) begin
                r_idx <= '0; r_pf <= 1'b0; r_prev <= '0;
            end else begin
                // Pre-fetch cycle reads entry start-1 so TOR has its lower bound.
                r_idx <= entry_start_i - IW'(1); r_pf <= 1'b1;
            end
        end else if (r_state == S_SCAN) begin
            r_prev <= {entry_addrh_i, entry_addr_i};
            if (!w_done) r_idx <= r_idx + IW'(1);
            if (r_pf) begin
                r_pf <= 1'b0;
            end else begin
                if (w_np_grant && !r_granted) begin r_granted <= 1'b1; r_gidx <= w_cur; end
                if (w_np_deny && !r_cand)     begin r_cand    <= 1'b1; r_cidx <= w_cur; end
                if (w_done) begin
                    if (w_prio_hit) begin
                        r_hit <= 1'b1; r_allow <= w_allow;
                        r_err <= w_allow ? 2'd0 : 2'd1; r_ridx <= w_cur;
                    end else if (r_granted || w_np_grant) begin
                        r_hit <= 1'b1; r_allow <= 1'b1; r_err <= 2'd0;
                        r_ridx <= r_granted ? r_gidx : w_cur;
                    end else if (r_cand || w_np_deny) begin
                        r_hit <= 1'b1; r_allow <= 1'b0; r_err <= 2'd1;
                        r_ridx <= r_cand ? r_cidx : w_cur;
                    end else begin
                        r_hit <= 1'b0; r_allow <= 1'b0; r_err <= 2'd2; r_ridx <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rv_iopmp_entry_scanner.sv
// Scoreboard bench for rv_iopmp_entry_scanner: byte-range reference model, random tables.
module tb_rv_iopmp_entry_scanner;
    localparam int IW = 5;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  req_valid_i = 1'b0;
    logic                  req_ready_o;
    logic [63:0]           req_addr_i = '0;
    logic [3:0]            req_num_bytes_i = '0;
    rv_iopmp_pkg::access_t req_type_i = '0;
    logic [IW-1:0]         entry_start_i = '0, entry_end_i = '0, prio_entry_i = '0;
    logic [IW-2:0]         entry_idx_o;
    logic [31:0]           entry_addr_i, entry_addrh_i;
    rv_iopmp_pkg::mode_t   entry_mode_i;
    logic [2:0]            entry_perm_i;
    logic                  rsp_valid_o, rsp_ready_i = 1'b1;
    logic                  rsp_allow_o, rsp_hit_o;
    logic [1:0]            rsp_err_o;
    logic [IW-2:0]         rsp_entry_idx_o;

    logic [31:0] t_addr [16];
    logic [31:0] t_addrh[16];
    logic [1:0]  t_mode [16];
    logic [2:0]  t_perm [16];

    assign entry_addr_i  = t_addr[entry_idx_o];
    assign entry_addrh_i = t_addrh[entry_idx_o];
    assign entry_mode_i  = rv_iopmp_pkg::mode_t'(t_mode[entry_idx_o]);
    assign entry_perm_i  = t_perm[entry_idx_o];

    rv_iopmp_entry_scanner dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_num_bytes_i(req_num_bytes_i), .req_type_i(req_type_i),
        .entry_start_i(entry_start_i), .entry_end_i(entry_end_i), .prio_entry_i(prio_entry_i),
        .entry_idx_o(entry_idx_o), .entry_addr_i(entry_addr_i), .entry_addrh_i(entry_addrh_i),
        .entry_mode_i(entry_mode_i), .entry_perm_i(entry_perm_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_allow_o(rsp_allow_o), .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o),
        .rsp_entry_idx_o(rsp_entry_idx_o)
    );

    typedef struct { bit allow; bit hit; int err; int idx; int lat; int acc; } exp_t;
    exp_t sb[$];
    exp_t cur;
    int   checks = 0, failures = 0;
    int   cyc = 0;
    bit   ready_rand = 1'b0;
    logic ready_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        rsp_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte range [lo,hi) covered by entry i, straight from the PMP address encodings.
    function automatic void region(input int i, output logic [79:0] lo, output logic [79:0] hi);
        logic [79:0] e, p;
        int t;
        e = {16'b0, t_addrh[i], t_addr[i]};
        p = '0;
        if (i > 0) p = {16'b0, t_addrh[i-1], t_addr[i-1]};
        lo = '0; hi = '0;
        case (t_mode[i])
            2'd1: begin lo = p * 4; hi = e * 4; end
            2'd2: begin lo = e * 4; hi = lo + 4; end
            2'd3: begin
                t = 0;
                while (t < 64 && e[t]) t++;
                lo = ((e >> (t + 1)) << (t + 1)) * 4;
                hi = lo + (80'd1 << (t + 3));
            end
            default: ;
        endcase
    endfunction

    function automatic exp_t model(input int s, input int en, input int p,
                                   input logic [63:0] a, input int nb, input logic [2:0] ty);
        exp_t r;
        logic [79:0] lo, hi, b, f;
        bit m, ok, done, g, c;
        int gi, ci, scanned;
        r.allow = 0; r.hit = 0; r.err = 2; r.idx = 0; r.acc = 0;
        done = 0; g = 0; c = 0; gi = 0; ci = 0;
        if (s >= en) begin r.lat = 1; return r; end
        scanned = en - s;
        b = {16'b0, a};
        f = b + nb;
        for (int i = s; i < en && !done; i++) begin
            region(i, lo, hi);
            m  = (lo < hi) && (b < hi) && (f > lo);
            ok = m && (b >= lo) && (f <= hi) && ((ty & ~t_perm[i]) == 3'b0);
            if (i < p) begin
                if (m) begin
                    done = 1; r.hit = 1; r.allow = ok; r.err = ok ? 0 : 1; r.idx = i;
                    scanned = i - s + 1;
                end
            end else begin
                if (ok && !g) begin
                    g = 1; gi = i;
`ifdef RV_IOPMP_SCAN_EARLY_EXIT_EN
                    done = 1; scanned = i - s + 1;
`endif
                end
                if (m && !ok && !c) begin c = 1; ci = i; end
            end
        end
        if (!r.hit) begin
            if (g)      begin r.hit = 1; r.allow = 1; r.err = 0; r.idx = gi; end
            else if (c) begin r.hit = 1; r.allow = 0; r.err = 1; r.idx = ci; end
        end
        r.lat = scanned + 1 + ((s != 0) ? 1 : 0);
        return r;
    endfunction

    // Monitor: value/latency check on first sight, stability while held.
    bit seen = 0;
    logic p_allow, p_hit;
    logic [1:0] p_err;
    logic [3:0] p_idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else if (rsp_valid_o) begin
            chk("busy_req_ready", req_ready_o, 0);
            if (!seen) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp actual=valid expected=idle");
                end else begin
                    cur = sb[0];
                    chk("allow", rsp_allow_o, cur.allow);
                    chk("hit", rsp_hit_o, cur.hit);
                    chk("err", rsp_err_o, cur.err);
                    chk("idx", rsp_entry_idx_o, cur.idx);
                    chk("latency", cyc - cur.acc, cur.lat);
                end
                seen = 1;
            end else begin
                chk("hold_allow", rsp_allow_o, p_allow);
                chk("hold_hit", rsp_hit_o, p_hit);
                chk("hold_err", rsp_err_o, p_err);
                chk("hold_idx", rsp_entry_idx_o, p_idx);
            end
            p_allow = rsp_allow_o; p_hit = rsp_hit_o; p_err = rsp_err_o; p_idx = rsp_entry_idx_o;
            if (rsp_ready_i) begin
                if (sb.size() > 0) void'(sb.pop_front());
                seen = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input int s, input int en, input int p, input logic [63:0] a,
                        input int nb, input logic [2:0] ty);
        exp_t e;
        int w = 0;
        @(negedge clk);
        while (!req_ready_o && w < 500) begin @(negedge clk); w++; end
        if (!req_ready_o) begin
            checks++; failures++;
            $display("FAIL ready_timeout actual=0 expected=1");
            return;
        end
        req_valid_i = 1'b1; req_addr_i = a; req_num_bytes_i = 4'(nb); req_type_i = ty;
        entry_start_i = IW'(s); entry_end_i = IW'(en); prio_entry_i = IW'(p);
        e = model(s, en, p, a, nb, ty);
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        // Scramble the request bus to prove the latched copy is used.
        req_valid_i = 1'b0; req_addr_i = {$urandom, $urandom}; req_num_bytes_i = 4'($urandom);
        req_type_i = 3'($urandom); entry_start_i = IW'($urandom); entry_end_i = IW'($urandom);
        prio_entry_i = IW'($urandom);
    endtask

    task automatic wait_done();
        int w = 0;
        while (sb.size() != 0 && w < 400) begin @(negedge clk); w++; end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=%0d pending expected=0", sb.size());
            do_reset();
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 16; i++) begin
            t_addr[i] = '0; t_addrh[i] = '0; t_mode[i] = 2'd0; t_perm[i] = 3'd0;
        end
    endtask

    task automatic rand_table();
        int t;
        for (int i = 0; i < 16; i++) begin
            t_mode[i]  = 2'($urandom_range(0, 3));
            t_addrh[i] = '0;
            t_perm[i]  = 3'($urandom_range(0, 7));
            t_addr[i]  = 32'($urandom_range(0, 'h1000));
            if (t_mode[i] == 2'd3) begin
                t = $urandom_range(0, 6);
                t_addr[i] = (t_addr[i] & ~((32'd1 << (t + 1)) - 1)) | ((32'd1 << t) - 1);
            end
        end
    endtask

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        clear_table();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_allow", rsp_allow_o, 0);
        chk("rst_hit", rsp_hit_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_rsp_idx", rsp_entry_idx_o, 0);
        chk("rst_entry_idx", entry_idx_o, 0);
        rst_n = 1'b1;

        // TOR entry0 covering [0,0x1000), read allowed then write denied.
        t_mode[0] = 2'd1; t_addr[0] = 32'h400; t_perm[0] = 3'b001;
        send(0, 4, 4, 64'h800, 4, 3'b001); wait_done();
        send(0, 4, 4, 64'h800, 4, 3'b010); wait_done();

        clear_table();
        send(2, 6, 0, 64'h800, 4, 3'b001); wait_done();

        // Priority NAPOT deny beats later non-priority allow.
        t_mode[3] = 2'd3; t_addr[3] = 32'h803; t_perm[3] = 3'b001;
        t_mode[5] = 2'd3; t_addr[5] = 32'h803; t_perm[5] = 3'b011;
        send(3, 6, 4, 64'h2010, 4, 3'b010); wait_done();

        clear_table();
        t_mode[4] = 2'd3; t_addr[4] = 32'h803; t_perm[4] = 3'b000;
        t_mode[6] = 2'd3; t_addr[6] = 32'h803; t_perm[6] = 3'b011;
        send(4, 8, 4, 64'h2010, 4, 3'b001); wait_done();

        // Domain ends at the table size; empty and inverted domains.
        clear_table();
        t_mode[14] = 2'd1; t_addr[14] = 32'h100; t_perm[14] = 3'b111;
        t_mode[15] = 2'd1; t_addr[15] = 32'h200; t_perm[15] = 3'b111;
        send(12, 16, 0, 64'h500, 8, 3'b100); wait_done();
        send(5, 5, 0, 64'h500, 8, 3'b100); wait_done();
        send(9, 3, 0, 64'h500, 8, 3'b100); wait_done();

        // Backpressure: verdict held for 5 cycles.
        t_mode[0] = 2'd1; t_addr[0] = 32'h400; t_perm[0] = 3'b001;
        ready_force = 1'b0;
        send(0, 4, 4, 64'h800, 4, 3'b001);
        for (int w = 0; w < 50 && !rsp_valid_o; w++) @(negedge clk);
        repeat (5) @(negedge clk);
        ready_force = 1'b1;
        wait_done();

        // Reset in the middle of a long scan.
        clear_table();
        send(0, 16, 0, 64'h10, 4, 3'b001);
        repeat (3) @(negedge clk);
        chk("scan_req_ready", req_ready_o, 0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_rsp_valid", rsp_valid_o, 0);
        chk("midrst_req_ready", req_ready_o, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        ready_rand = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int s, e, p;
            rand_table();
            s = $urandom_range(0, 16);
            e = $urandom_range(0, 16);
            if (s >= e && ($urandom_range(0, 7) != 0)) begin
                s = $urandom_range(0, 15);
                e = $urandom_range(s + 1, 16);
            end
            p = $urandom_range(0, 16);
            send(s, e, p, 64'($urandom_range(0, 'h4400)), $urandom_range(1, 8),
                 3'(1 << $urandom_range(0, 2)));
            wait_done();
        end
        ready_rand = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
